// File: rtl/stack_engine_if.sv
// Command/status bundle between the processor control and the stack engine.
interface stack_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [1:0]        rw;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] r0;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W:0]   sp;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output rw, din, r0, err_clr,
    input  dout, dout_valid, sp, full, empty, overflow, underflow
  );

  modport slave (
    input  rw, din, r0, err_clr,
    output dout, dout_valid, sp, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_engine.sv
// LIFO stack with on-chip storage, registered pop data and sticky error flags.
// Define STACK_WRAP_EN to turn a push-while-full into a circular overwrite.
module stack_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  stack_engine_if.slave bus
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_TP = ADDR_W'(1);

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_tp;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;

  cmd_e              w_cmd;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_tp_inc;
  logic [ADDR_W-1:0] w_tp_dec;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_mem_we;
  logic              w_pop_acc;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic [ADDR_W:0]   w_load_count;

  function automatic logic load_exceeds(input logic [DATA_W-1:0] v);
    return 64'(v) > 64'(DEPTH);
  endfunction

  // Saturate an out-of-range load to a full stack; low bits of DEPTH are zero so tp wraps to 0.
  function automatic logic [ADDR_W:0] sat_load(input logic [DATA_W-1:0] v);
    return load_exceeds(v) ? DEPTH_C : (ADDR_W+1)'(v);
  endfunction

  assign w_cmd        = cmd_e'(bus.rw);
  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  assign w_tp_inc     = r_tp + ONE_TP;
  assign w_tp_dec     = r_tp - ONE_TP;
  assign w_push       = (w_cmd == CMD_PUSH);
  assign w_pop        = (w_cmd == CMD_POP);
  assign w_load       = (w_cmd == CMD_LOAD);
  assign w_pop_acc    = w_pop & ~w_empty;
  assign w_load_count = sat_load(bus.r0);
  assign w_ovf_evt    = (w_push & w_full) | (w_load & load_exceeds(bus.r0));
  assign w_unf_evt    = w_pop & w_empty;

`ifdef STACK_WRAP_EN
  assign w_mem_we = w_push & ~rst;
`else
  assign w_mem_we = w_push & ~w_full & ~rst;
`endif

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_tp] <= bus.din;
    end
  end

  // Pop data is registered: dout/dout_valid appear the cycle after the accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp         <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_pop_acc;
      if (w_pop_acc) begin
        r_dout <= r_mem[w_tp_dec];
      end
      case (w_cmd)
        CMD_PUSH: begin
          if (w_mem_we) begin
            r_tp <= w_tp_inc;
          end
          if (!w_full) begin
            r_count <= r_count + ONE_CNT;
          end
        end
        CMD_POP: begin
          if (!w_empty) begin
            r_tp    <= w_tp_dec;
            r_count <= r_count - ONE_CNT;
          end
        end
        CMD_LOAD: begin
          r_count <= w_load_count;
          r_tp    <= w_load_count[ADDR_W-1:0];
        end
        default: begin
        end
      endcase
      // A new error event beats a simultaneous clear.
      r_overflow  <= w_ovf_evt | (r_overflow & ~bus.err_clr);
      r_underflow <= w_unf_evt | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.sp         = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine at DATA_W=8, ADDR_W=2 (depth 4).
module tb_stack_engine;

  logic clk;
  logic rst;

  stack_engine_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  stack_engine #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the stack as specified.
  logic [7:0] m_mem [4];
  int         m_tp;
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_vld;
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] sb_q [$];

  task automatic drive(input logic [1:0] cmd, input logic [7:0] d, input logic [7:0] r,
                       input logic clr, input logic rs);
    bus.rw      = cmd;
    bus.din     = d;
    bus.r0      = r;
    bus.err_clr = clr;
    rst         = rs;
    m_vld       = 1'b0;
    if (rs) begin
      m_tp = 0; m_cnt = 0; m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      case (cmd)
        2'b01: begin
          if (m_cnt < 4) begin
            m_mem[m_tp] = d; m_tp = (m_tp + 1) % 4; m_cnt++;
          end else begin
            m_ovf = 1'b1;
`ifdef STACK_WRAP_EN
            m_mem[m_tp] = d; m_tp = (m_tp + 1) % 4;
`endif
          end
        end
        2'b10: begin
          if (m_cnt > 0) begin
            m_tp = (m_tp + 3) % 4; m_dout = m_mem[m_tp]; m_cnt--; m_vld = 1'b1;
            sb_q.push_back(m_dout);
          end else begin
            m_unf = 1'b1;
          end
        end
        2'b11: begin
          if (r <= 8'd4) begin m_cnt = int'(r); m_tp = int'(r) % 4; end
          else begin m_cnt = 4; m_tp = 0; m_ovf = 1'b1; end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++; if (bus.sp !== 3'd0) $display("FAIL reset_sp got %0d want 0", bus.sp); else n_pass++;
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got %h want 00", bus.dout); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.dout_valid); else n_pass++;
    n_checks++; if ({bus.empty, bus.full} !== 2'b10) $display("FAIL reset_empty_full got %b want 10", {bus.empty, bus.full}); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
  endtask

  task automatic test_lifo();
    logic [1:0] cmds [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [7:0] data [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(cmds[i], data[i], 8'h00, 1'b0, 1'b0);
      n_checks++; if (bus.dout_valid !== m_vld) $display("FAIL lifo_valid step %0d got %b want %b", i, bus.dout_valid, m_vld); else n_pass++;
      if (bus.dout_valid === 1'b1) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++; if (bus.dout !== exp) $display("FAIL lifo_dout step %0d got %h want %h", i, bus.dout, exp); else n_pass++;
      end
      n_checks++; if (bus.sp !== 3'(m_cnt)) $display("FAIL lifo_sp step %0d got %0d want %0d", i, bus.sp, m_cnt); else n_pass++;
    end
    n_checks++; if (bus.dout !== 8'h11) $display("FAIL lifo_last_dout got %h want 11", bus.dout); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL lifo_empty got %b want 1", bus.empty); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL lifo_flags got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    logic [7:0] first_exp;
`ifdef STACK_WRAP_EN
    first_exp = 8'hA4;
`else
    first_exp = 8'hA3;
`endif
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 8'hA0 + 8'(i), 8'h00, 1'b0, 1'b0);
      n_checks++; if (bus.sp !== 3'(m_cnt)) $display("FAIL ovf_push_sp step %0d got %0d want %0d", i, bus.sp, m_cnt); else n_pass++;
      n_checks++; if (bus.full !== (m_cnt == 4)) $display("FAIL ovf_full step %0d got %b want %b", i, bus.full, m_cnt == 4); else n_pass++;
      n_checks++; if (bus.overflow !== m_ovf) $display("FAIL ovf_flag step %0d got %b want %b", i, bus.overflow, m_ovf); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (bus.dout_valid !== 1'b1) $display("FAIL ovf_pop_valid step %0d got %b want 1", i, bus.dout_valid); else n_pass++;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      n_checks++; if (bus.dout !== exp) $display("FAIL ovf_pop_dout step %0d got %h want %h", i, bus.dout, exp); else n_pass++;
      if (i == 0) begin
        n_checks++; if (bus.dout !== first_exp) $display("FAIL ovf_first_pop got %h want %h", bus.dout, first_exp); else n_pass++;
      end
    end
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL ovf_drained_empty got %b want 1", bus.empty); else n_pass++;
  endtask

  task automatic test_underflow();
    logic [1:0] cmds [3] = '{2'b10, 2'b10, 2'b00};
    logic       clrs [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] held;
    held = bus.dout;
    for (int i = 0; i < 3; i++) begin
      drive(cmds[i], 8'h00, 8'h00, clrs[i], 1'b0);
      n_checks++; if (bus.underflow !== m_unf) $display("FAIL unf_flag step %0d got %b want %b", i, bus.underflow, m_unf); else n_pass++;
      n_checks++; if (bus.overflow !== m_ovf) $display("FAIL unf_ovf step %0d got %b want %b", i, bus.overflow, m_ovf); else n_pass++;
      n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL unf_valid step %0d got %b want 0", i, bus.dout_valid); else n_pass++;
      n_checks++; if (bus.dout !== held) $display("FAIL unf_dout_hold step %0d got %h want %h", i, bus.dout, held); else n_pass++;
    end
    n_checks++; if (bus.underflow !== 1'b0) $display("FAIL unf_cleared got %b want 0", bus.underflow); else n_pass++;
  endtask

  task automatic test_load();
    logic [7:0] exp;
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(2'b01, 8'h55, 8'h00, 1'b0, 1'b0);
    drive(2'b01, 8'h66, 8'h00, 1'b0, 1'b0);
    drive(2'b11, 8'h00, 8'h01, 1'b0, 1'b0);
    n_checks++; if (bus.sp !== 3'd1) $display("FAIL load_sp got %0d want 1", bus.sp); else n_pass++;
    drive(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    n_checks++; if (bus.dout_valid !== 1'b1) $display("FAIL load_pop_valid got %b want 1", bus.dout_valid); else n_pass++;
    n_checks++; if (bus.dout !== exp) $display("FAIL load_pop_dout got %h want %h", bus.dout, exp); else n_pass++;
    n_checks++; if (bus.dout !== 8'h55) $display("FAIL load_pop_55 got %h want 55", bus.dout); else n_pass++;
    drive(2'b11, 8'h00, 8'h09, 1'b0, 1'b0);
    n_checks++; if (bus.sp !== 3'd4) $display("FAIL load_sat_sp got %0d want 4", bus.sp); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL load_sat_ovf got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.full !== 1'b1) $display("FAIL load_sat_full got %b want 1", bus.full); else n_pass++;
  endtask

  task automatic test_reset_override();
    drive(2'b01, 8'h77, 8'h00, 1'b0, 1'b1);
    n_checks++; if (bus.sp !== 3'd0) $display("FAIL rstov_sp got %0d want 0", bus.sp); else n_pass++;
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL rstov_dout got %h want 00", bus.dout); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL rstov_valid got %b want 0", bus.dout_valid); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL rstov_flags got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
    drive(2'b10, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (bus.underflow !== 1'b1) $display("FAIL rstov_unf got %b want 1", bus.underflow); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL rstov_pop_valid got %b want 0", bus.dout_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10, 8'hC1, 8'h00, 1'b0, 1'b0);
      n_checks++; if (bus.dout_valid !== m_vld) $display("FAIL b2b_valid step %0d got %b want %b", i, bus.dout_valid, m_vld); else n_pass++;
      if (bus.dout_valid === 1'b1) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++; if (bus.dout !== exp) $display("FAIL b2b_dout step %0d got %h want %h", i, bus.dout, exp); else n_pass++;
      end
      n_checks++; if (bus.sp !== ((i % 2 == 0) ? 3'd1 : 3'd0)) $display("FAIL b2b_sp step %0d got %0d want %0d", i, bus.sp, (i % 2 == 0) ? 1 : 0); else n_pass++;
      n_checks++; if (bus.full !== 1'b0) $display("FAIL b2b_full step %0d got %b want 0", i, bus.full); else n_pass++;
      n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL b2b_flags step %0d got %b want 00", i, {bus.overflow, bus.underflow}); else n_pass++;
    end
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b want 0", bus.dout_valid); else n_pass++;
    n_checks++; if (bus.dout !== 8'hC1) $display("FAIL b2b_idle_dout got %h want c1", bus.dout); else n_pass++;
  endtask

  initial begin
    rst         = 1'b1;
    bus.rw      = 2'b00;
    bus.din     = 8'h00;
    bus.r0      = 8'h00;
    bus.err_clr = 1'b0;
    m_tp = 0; m_cnt = 0; m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_load();
    test_reset_override();
    test_back_to_back();
    n_checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised hardware stack for the pipelined processor. It supersedes the bare pointer-only stack unit and adds on-chip storage, a registered pop-data path, full/empty status and sticky overflow/underflow error flags.
- It keeps the processor's existing 2-bit `rw` command encoding: 00 idle, 01 push, 10 pop, 11 load pointer from R0.
- It is driven by CCG3 control and the register array.

Parameters:
- DATA_W, 8, width of each stack entry and of push/pop data.
- ADDR_W, 4, storage index width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rw  input  2  command: 00 none, 01 push, 10 pop, 11 load count from r0.
- din  input  DATA_W  push data.
- r0  input  DATA_W  load value for command 11.
- err_clr  input  1  clears sticky error flags.
- dout  output  DATA_W  popped data, registered.
- dout_valid  output  1  one-cycle pulse, cycle after an accepted pop.
- sp  output  ADDR_W+1  current entry count, 0..DEPTH.
- full  output  1  sp == DEPTH, combinational from state.
- empty  output  1  sp == 0, combinational from state.
- overflow  output  1  sticky: push attempted while full, or load value > DEPTH.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
Internal state:
- mem[DEPTH] of DATA_W.
- top pointer tp (ADDR_W bits): next write index.
- count (ADDR_W+1 bits), drives sp.

Reset (rst=1 at edge):
- tp=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- mem contents are not cleared.
- rst overrides any command in the same cycle.

Push (01):
- not full: mem[tp]<=din; tp<=tp+1 (mod DEPTH); count+1.
- full: see Optional Feature; overflow<=1.

Pop (10):
- not empty: dout<=mem[tp-1]; tp<=tp-1 (mod DEPTH); count-1; dout_valid=1 next cycle.
- empty: no state change, dout holds, dout_valid=0, underflow<=1.
- Pop latency is exactly 1 cycle.
- A push in the cycle after a pop reuses the freed slot.

Load (11):
- v = r0 (unsigned).
- v <= DEPTH: count<=v; tp<=v[ADDR_W-1:0].
- v > DEPTH: count<=DEPTH, tp<=0, overflow<=1.
- Memory is untouched.

Idle (00): no change; dout_valid<=0.

General rules:
- dout_valid is 0 in every cycle not following an accepted pop.
- dout keeps its last popped value until the next accepted pop or reset.

Error flags:
- Sticky until err_clr=1 at an edge.
- If err_clr and a new error event occur in the same cycle, the flag ends set (the event wins).

Read-during-write:
- Not possible, since only one command is issued per cycle.
- Memory is a single-write, single-read array; inferable as distributed RAM.

Optional Feature:
- Macro: STACK_WRAP_EN.
- Defined: push while full is accepted as a circular overwrite.
  - mem[tp]<=din; tp<=tp+1; count stays DEPTH; overflow<=1.
  - The oldest entry is lost; subsequent pops return the newest DEPTH entries in LIFO order.
- Undefined: push while full is dropped. tp, count and mem are unchanged; overflow<=1.
- Underflow and load behaviour are identical in both builds.

Test Plan:
(Overridden ADDR_W=2, DEPTH=4, DATA_W=8.)
1. Reset, then push 0x11,0x22,0x33, then pop ×3 -> dout 0x33,0x22,0x11, each one cycle after its pop with dout_valid=1; sp 3→0; empty=1 at end; no error flags.
2. Push 0xA0..0xA3 (full=1, sp=4), then push 0xA4:
   - without STACK_WRAP_EN: overflow=1, sp=4; pops return A3,A2,A1,A0.
   - with STACK_WRAP_EN: overflow=1, sp=4; pops return A4,A3,A2,A1.
3. Pop on empty stack -> underflow=1, dout unchanged, dout_valid=0. Next cycle err_clr=1 with a second empty pop -> underflow stays 1. Then err_clr alone -> underflow=0.
4. Push 0x55,0x66; load r0=0x01 -> sp=1; pop -> dout=0x55. Load r0=0x09 -> sp=4, overflow=1.
5. Push 0x77 with rst=1 in the same cycle -> sp=0, dout=0, dout_valid=0, flags 0. Pop afterwards -> underflow=1.
6. Alternating push 0xC1 / pop for 8 cycles -> each pop returns 0xC1, sp toggles 1/0, full never asserts, no flags.
